// File: rtl/debug_unit.sv
// debug_unit: UART-driven program loader, run/step controller and PC/register/memory dumper for the MIPS core.
// Optional macro DEBUG_CYCLE_CNT_EN adds a saturating enabled-cycle counter sent right after PC in each dump.

module debug_unit #(
    parameter int unsigned         INST_SZ    = 32,
    parameter int unsigned         PC_SZ      = 32,
    parameter int unsigned         REG_SZ     = 5,
    parameter int unsigned         BYTE_SZ    = 8,
    parameter int unsigned         MAX_INSTR  = 256,
    parameter logic [INST_SZ-1:0]  HALT_INSTR = 32'hFFFF_FFFF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [BYTE_SZ-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    output logic [BYTE_SZ-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_write,
    output logic               o_enable,
    output logic [INST_SZ-1:0] o_instruction,
    output logic [REG_SZ-1:0]  o_debug_addr,
    input  logic [PC_SZ-1:0]   i_pc,
    input  logic [INST_SZ-1:0] i_reg,
    input  logic [INST_SZ-1:0] i_mem,
    input  logic               i_halt
);

    localparam int unsigned BYTES = INST_SZ / BYTE_SZ;
    localparam int unsigned BC_W  = $clog2(BYTES);
    localparam int unsigned WC_W  = $clog2(MAX_INSTR + 1);
    localparam logic [BC_W-1:0]    LAST_BYTE = BC_W'(BYTES - 1);
    localparam logic [WC_W-1:0]    LAST_WORD = WC_W'(MAX_INSTR - 1);
    localparam logic [BYTE_SZ-1:0] CMD_LOAD  = BYTE_SZ'(8'h4C);
    localparam logic [BYTE_SZ-1:0] CMD_RUN   = BYTE_SZ'(8'h43);
    localparam logic [BYTE_SZ-1:0] CMD_STEP  = BYTE_SZ'(8'h53);

    typedef enum logic [2:0] {
        IDLE, LOAD, RUN, STEP, DUMP_ADDR, DUMP_CAPTURE, TX_SEND, TX_WAIT
    } state_t;

    typedef enum logic [1:0] { PH_PC, PH_CNT, PH_REG, PH_MEM } phase_t;

    state_t             state, state_next;
    phase_t             phase, phase_next;
    logic [BC_W-1:0]    byte_cnt, byte_cnt_next;
    logic [WC_W-1:0]    word_cnt, word_cnt_next;
    logic [INST_SZ-1:0] shift, shift_next, load_word;
    logic [REG_SZ-1:0]  addr_next;
    logic [BYTE_SZ-1:0] tx_data_next;
    logic [INST_SZ-1:0] instruction_next;
    logic               halted, halted_next;
    logic               tx_start_next, write_next, enable_next, dump_go;

`ifdef DEBUG_CYCLE_CNT_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset || (state_next == LOAD && state != LOAD))
            cycle_cnt <= '0;
        else if (o_enable && cycle_cnt != '1)
            cycle_cnt <= cycle_cnt + 1'b1;
    end
`endif

    assign load_word = {shift[INST_SZ-BYTE_SZ-1:0], i_rx_data};

    always_comb begin
        state_next       = state;
        phase_next       = phase;
        byte_cnt_next    = byte_cnt;
        word_cnt_next    = word_cnt;
        shift_next       = shift;
        halted_next      = halted;
        addr_next        = o_debug_addr;
        tx_data_next     = o_tx_data;
        instruction_next = o_instruction;
        tx_start_next    = 1'b0;
        write_next       = 1'b0;
        enable_next      = 1'b0;
        dump_go          = 1'b0;

        case (state)
            IDLE: begin
                if (i_rx_done) begin
                    case (i_rx_data)
                        CMD_LOAD: begin
                            state_next    = LOAD;
                            halted_next   = 1'b0;
                            byte_cnt_next = '0;
                            word_cnt_next = '0;
                        end
                        CMD_RUN, CMD_STEP: begin
                            if (halted) begin
                                dump_go = 1'b1;
                            end else begin
                                enable_next = 1'b1;
                                state_next  = (i_rx_data == CMD_RUN) ? RUN : STEP;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            LOAD: begin
                if (i_rx_done) begin
                    shift_next    = load_word;
                    byte_cnt_next = byte_cnt + 1'b1;
                    if (byte_cnt == LAST_BYTE) begin
                        byte_cnt_next    = '0;
                        write_next       = 1'b1;
                        instruction_next = load_word;
                        word_cnt_next    = word_cnt + 1'b1;
                        if (load_word == HALT_INSTR || word_cnt == LAST_WORD)
                            state_next = IDLE;
                    end
                end
            end
            RUN: begin
                if (i_halt) begin
                    halted_next = 1'b1;
                    dump_go     = 1'b1;
                end else begin
                    enable_next = 1'b1;
                end
            end
            STEP: begin
                if (i_halt)
                    halted_next = 1'b1;
                dump_go = 1'b1;
            end
            DUMP_ADDR: state_next = DUMP_CAPTURE;
            DUMP_CAPTURE: begin
                shift_next = (phase == PH_MEM) ? i_mem : i_reg;
                state_next = TX_SEND;
            end
            TX_SEND: begin
                tx_start_next = 1'b1;
                tx_data_next  = shift[INST_SZ-1 -: BYTE_SZ];
                state_next    = TX_WAIT;
            end
            TX_WAIT: begin
                if (i_tx_done) begin
                    shift_next    = shift << BYTE_SZ;
                    byte_cnt_next = byte_cnt + 1'b1;
                    state_next    = TX_SEND;
                    if (byte_cnt == LAST_BYTE) begin
                        byte_cnt_next = '0;
                        // Word finished: pick the next source; address wraps 31->0 into memory phase
                        case (phase)
                            PH_PC: begin
`ifdef DEBUG_CYCLE_CNT_EN
                                phase_next = PH_CNT;
                                shift_next = INST_SZ'(cycle_cnt);
                                state_next = TX_SEND;
`else
                                phase_next = PH_REG;
                                addr_next  = '0;
                                state_next = DUMP_ADDR;
`endif
                            end
                            PH_CNT: begin
                                phase_next = PH_REG;
                                addr_next  = '0;
                                state_next = DUMP_ADDR;
                            end
                            PH_REG: begin
                                addr_next  = o_debug_addr + 1'b1;
                                phase_next = (o_debug_addr == '1) ? PH_MEM : PH_REG;
                                state_next = DUMP_ADDR;
                            end
                            default: begin
                                addr_next  = o_debug_addr + 1'b1;
                                state_next = (o_debug_addr == '1) ? IDLE : DUMP_ADDR;
                            end
                        endcase
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (dump_go) begin
            shift_next    = INST_SZ'(i_pc);
            phase_next    = PH_PC;
            byte_cnt_next = '0;
            state_next    = TX_SEND;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= IDLE;
            phase         <= PH_PC;
            byte_cnt      <= '0;
            word_cnt      <= '0;
            shift         <= '0;
            halted        <= 1'b0;
            o_debug_addr  <= '0;
            o_tx_data     <= '0;
            o_tx_start    <= 1'b0;
            o_write       <= 1'b0;
            o_enable      <= 1'b0;
            o_instruction <= '0;
        end else begin
            state         <= state_next;
            phase         <= phase_next;
            byte_cnt      <= byte_cnt_next;
            word_cnt      <= word_cnt_next;
            shift         <= shift_next;
            halted        <= halted_next;
            o_debug_addr  <= addr_next;
            o_tx_data     <= tx_data_next;
            o_tx_start    <= tx_start_next;
            o_write       <= write_next;
            o_enable      <= enable_next;
            o_instruction <= instruction_next;
        end
    end

endmodule

// File: tb/tb_debug_unit.sv
// tb_debug_unit: scoreboard bench for debug_unit; expected tx bytes and write words are queued as stimulus is driven.
// Build with DEBUG_CYCLE_CNT_EN defined to exercise the cycle-counter dump word.

module tb_debug_unit;

`ifdef DEBUG_CYCLE_CNT_EN
    localparam int DUMP_LEN = 264;
    logic [31:0] exp_cycles = '0;
`else
    localparam int DUMP_LEN = 260;
`endif

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [7:0]  i_rx_data = '0;
    logic        i_rx_done = 1'b0;
    logic        i_tx_done = 1'b0;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        o_write;
    logic        o_enable;
    logic [31:0] o_instruction;
    logic [4:0]  o_debug_addr;
    logic [31:0] i_pc = '0;
    logic [31:0] i_reg = '0;
    logic [31:0] i_mem = '0;
    logic        i_halt = 1'b0;

    int checks = 0;
    int passes = 0;
    int tx_cnt = 0;
    int wr_cnt = 0;
    int en_cycles = 0;
    int dly = 0;
    logic [7:0]  txq[$];
    logic [31:0] wq[$];
    logic [7:0]  exp_b;
    logic [31:0] exp_w;

    debug_unit #(.INST_SZ(32), .PC_SZ(32), .REG_SZ(5), .BYTE_SZ(8), .MAX_INSTR(256)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
        .i_tx_done(i_tx_done), .o_tx_data(o_tx_data), .o_tx_start(o_tx_start),
        .o_write(o_write), .o_enable(o_enable), .o_instruction(o_instruction),
        .o_debug_addr(o_debug_addr), .i_pc(i_pc), .i_reg(i_reg), .i_mem(i_mem), .i_halt(i_halt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] reg_val(input logic [4:0] a);
        return (a == 5'd3) ? 32'h1122_3344 : (32'hA5A5_0000 | 32'(a));
    endfunction

    function automatic logic [31:0] mem_val(input logic [4:0] a);
        return 32'h5A5A_0000 + 32'(a) * 32'h0000_0101;
    endfunction

    // Core-side register file and data memory with one cycle of read latency
    always @(posedge clk) begin
        i_reg <= reg_val(o_debug_addr);
        i_mem <= mem_val(o_debug_addr);
    end

    always @(negedge clk) begin
        if (i_tx_done) i_tx_done = 1'b0;
        if (o_tx_start) dly = 10;
        else if (dly > 0) begin
            dly--;
            if (dly == 0) i_tx_done = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (o_enable) en_cycles++;
        if (o_tx_start) begin
            tx_cnt++;
            checks++;
            if (txq.size() == 0) $display("FAIL tx_byte: got %h, no byte expected", o_tx_data);
            else begin
                exp_b = txq.pop_front();
                if (o_tx_data !== exp_b) $display("FAIL tx_byte #%0d: got %h, want %h", tx_cnt, o_tx_data, exp_b);
                else passes++;
            end
        end
        if (o_write) begin
            wr_cnt++;
            checks++;
            if (wq.size() == 0) $display("FAIL imem_write: got %h, no write expected", o_instruction);
            else begin
                exp_w = wq.pop_front();
                if (o_instruction !== exp_w) $display("FAIL imem_write #%0d: got %h, want %h", wr_cnt, o_instruction, exp_w);
                else passes++;
            end
        end
    end

    task automatic push_word(input logic [31:0] w);
        for (int j = 3; j >= 0; j--) txq.push_back(w[j*8 +: 8]);
    endtask

    task automatic push_dump(input logic [31:0] pc);
        push_word(pc);
`ifdef DEBUG_CYCLE_CNT_EN
        push_word(exp_cycles);
`endif
        for (int i = 0; i < 32; i++) push_word(reg_val(5'(i)));
        for (int i = 0; i < 32; i++) push_word(mem_val(5'(i)));
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        i_rx_data = b;
        i_rx_done = 1'b1;
        @(negedge clk);
        i_rx_done = 1'b0;
    endtask

    // Leaves i_rx_done high so consecutive calls give back-to-back bytes
    task automatic send_word_fast(input logic [31:0] w);
        for (int j = 3; j >= 0; j--) begin
            @(negedge clk);
            i_rx_data = w[j*8 +: 8];
            i_rx_done = 1'b1;
        end
    endtask

    task automatic wait_tx(input int target);
        for (int k = 0; k < 8000 && tx_cnt < target; k++) @(negedge clk);
        tick(20);
    endtask

    task automatic test_reset;
        i_reset = 1'b1;
        tick(3);
        checks++;
        if ({o_tx_data, o_tx_start, o_write, o_enable, o_instruction, o_debug_addr} !== '0)
            $display("FAIL reset_outputs: got %h, want 0", {o_tx_data, o_tx_start, o_write, o_enable, o_instruction, o_debug_addr});
        else passes++;
        i_reset = 1'b0;
        tick(2);
    endtask

    task automatic test_load;
        int base = wr_cnt;
        wq.push_back(32'h2001_0005);
        wq.push_back(32'hFFFF_FFFF);
        send_byte(8'h4C);
        send_word_fast(32'h2001_0005);
        send_word_fast(32'hFFFF_FFFF);
        @(negedge clk);
        i_rx_done = 1'b0;
        tick(5);
        checks++;
        if (wr_cnt - base !== 2) $display("FAIL load_writes: got %0d, want 2", wr_cnt - base);
        else passes++;
        checks++;
        if (wq.size() !== 0) $display("FAIL load_pending: got %0d, want 0", wq.size());
        else passes++;
`ifdef DEBUG_CYCLE_CNT_EN
        exp_cycles = '0;
`endif
    endtask

    task automatic test_step;
        int base = tx_cnt;
        en_cycles = 0;
        i_pc = 32'h0000_0004;
`ifdef DEBUG_CYCLE_CNT_EN
        exp_cycles = exp_cycles + 1;
`endif
        push_dump(32'h0000_0004);
        send_byte(8'h53);
        tick(40);
        send_byte(8'h43);
        wait_tx(base + DUMP_LEN);
        checks++;
        if (en_cycles !== 1) $display("FAIL step_enable: got %0d cycles, want 1", en_cycles);
        else passes++;
        checks++;
        if (tx_cnt - base !== DUMP_LEN) $display("FAIL step_dump_len: got %0d, want %0d", tx_cnt - base, DUMP_LEN);
        else passes++;
        checks++;
        if (o_debug_addr !== 5'd0) $display("FAIL step_addr_wrap: got %0d, want 0", o_debug_addr);
        else passes++;
    endtask

    task automatic test_load_max;
        int base = wr_cnt;
        int tbase = tx_cnt;
        for (int i = 0; i < 256; i++) wq.push_back(32'h1000_0000 + 32'(i));
        send_byte(8'h4C);
        for (int i = 0; i < 256; i++) send_word_fast(32'h1000_0000 + 32'(i));
        send_word_fast(32'h0102_0304);
        @(negedge clk);
        i_rx_done = 1'b0;
        tick(20);
        checks++;
        if (wr_cnt - base !== 256) $display("FAIL load_max_writes: got %0d, want 256", wr_cnt - base);
        else passes++;
        checks++;
        if (tx_cnt !== tbase) $display("FAIL load_max_tx: got %0d, want %0d", tx_cnt, tbase);
        else passes++;
`ifdef DEBUG_CYCLE_CNT_EN
        exp_cycles = '0;
`endif
    endtask

    task automatic test_run;
        int base = tx_cnt;
        int n = 0;
        en_cycles = 0;
        i_pc = 32'h0000_001C;
`ifdef DEBUG_CYCLE_CNT_EN
        exp_cycles = exp_cycles + 7;
`endif
        push_dump(32'h0000_001C);
        send_byte(8'h43);
        for (int k = 0; k < 50; k++) begin
            if (o_enable) n++;
            if (n == 7) begin
                i_halt = 1'b1;
                break;
            end
            @(negedge clk);
        end
        wait_tx(base + DUMP_LEN);
        checks++;
        if (en_cycles !== 7) $display("FAIL run_enable: got %0d cycles, want 7", en_cycles);
        else passes++;
        checks++;
        if (tx_cnt - base !== DUMP_LEN) $display("FAIL run_dump_len: got %0d, want %0d", tx_cnt - base, DUMP_LEN);
        else passes++;
    endtask

    task automatic test_run_halted;
        int base = tx_cnt;
        en_cycles = 0;
        push_dump(32'h0000_001C);
        send_byte(8'h43);
        wait_tx(base + DUMP_LEN);
        checks++;
        if (en_cycles !== 0) $display("FAIL halted_enable: got %0d cycles, want 0", en_cycles);
        else passes++;
        checks++;
        if (tx_cnt - base !== DUMP_LEN) $display("FAIL halted_dump_len: got %0d, want %0d", tx_cnt - base, DUMP_LEN);
        else passes++;
    endtask

    task automatic test_unknown_and_reset;
        int base = tx_cnt;
        int snap;
        int wsnap;
        en_cycles = 0;
        send_byte(8'h58);
        tick(20);
        checks++;
        if (tx_cnt !== base || en_cycles !== 0)
            $display("FAIL unknown_cmd: got tx %0d en %0d, want tx %0d en 0", tx_cnt, en_cycles, base);
        else passes++;
        push_dump(32'h0000_001C);
        send_byte(8'h53);
        for (int k = 0; k < 2000 && tx_cnt < base + 30; k++) @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({o_tx_data, o_tx_start, o_write, o_enable, o_instruction, o_debug_addr} !== '0)
            $display("FAIL midreset_outputs: got %h, want 0", {o_tx_data, o_tx_start, o_write, o_enable, o_instruction, o_debug_addr});
        else passes++;
        txq.delete();
        snap = tx_cnt;
        wsnap = wr_cnt;
        tick(2);
        i_reset = 1'b0;
        tick(150);
        checks++;
        if (tx_cnt !== snap || wr_cnt !== wsnap || en_cycles !== 0)
            $display("FAIL post_reset_quiet: got tx %0d wr %0d en %0d, want tx %0d wr %0d en 0", tx_cnt, wr_cnt, en_cycles, snap, wsnap);
        else passes++;
        checks++;
        if ({o_tx_data, o_tx_start, o_write, o_enable, o_instruction, o_debug_addr} !== '0)
            $display("FAIL post_reset_outputs: got %h, want 0", {o_tx_data, o_tx_start, o_write, o_enable, o_instruction, o_debug_addr});
        else passes++;
    endtask

    initial begin
        test_reset;
        test_load;
        test_step;
        test_load_max;
        test_run;
        test_run_halted;
        test_unknown_and_reset;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
